// File: rtl/oclib_pkg.sv
// Shared CSR bus payload types.
//   csr_32_s    : CSR request (address, write data, read/write strobes)
//   csr_32_fb_s : CSR feedback (read data, ready, error)
package oclib_pkg;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wdata;
        logic        read;
        logic        write;
    } csr_32_s;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
        logic        error;
    } csr_32_fb_s;

endpackage

// File: rtl/oclib_words_to_csr_arb_if.sv
// Bundle of the word-stream requester ports and the CSR bus of the
// multi-port word-to-CSR bridge.
//   master : the environment (requesters drive words and take responses,
//            CSR target drives feedback)
//   slave  : the bridge itself
interface oclib_words_to_csr_arb_if #(
    parameter type         CsrType   = oclib_pkg::csr_32_s,
    parameter type         CsrFbType = oclib_pkg::csr_32_fb_s,
    parameter int unsigned Ports     = 2
);

    CsrType   [Ports-1:0] wordInData;
    logic     [Ports-1:0] wordInValid;
    logic     [Ports-1:0] wordInReady;
    CsrFbType [Ports-1:0] wordOutData;
    logic     [Ports-1:0] wordOutValid;
    logic     [Ports-1:0] wordOutReady;
    CsrType               csr;
    CsrFbType             csrFb;
    logic                 timeoutEvent;

    modport master (
        output wordInData, wordInValid, wordOutReady, csrFb,
        input  wordInReady, wordOutData, wordOutValid, csr, timeoutEvent
    );

    modport slave (
        input  wordInData, wordInValid, wordOutReady, csrFb,
        output wordInReady, wordOutData, wordOutValid, csr, timeoutEvent
    );

endinterface

// File: rtl/oclib_words_to_csr_arb.sv
// Multi-port word-to-CSR bridge: round-robin arbitration among Ports
// requesters, one CSR transaction in flight, bus timeout with error
// response, and local completion of null (no read, no write) requests.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : word request/response streams per port, CSR request bus,
//           CSR feedback bus and timeout pulse
module oclib_words_to_csr_arb #(
    parameter type         CsrType       = oclib_pkg::csr_32_s,
    parameter type         CsrFbType     = oclib_pkg::csr_32_fb_s,
    parameter int unsigned Ports         = 2,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                     clock,
    input  logic                     reset,
    oclib_words_to_csr_arb_if.slave  bus
);

    localparam int unsigned IdxW   = (Ports > 1) ? $clog2(Ports) : 1;
    localparam int unsigned TimerW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e              state,        stateNext;
    logic [IdxW-1:0]     lastGrant,    lastGrantNext;
    logic [IdxW-1:0]     owner,        ownerNext;
    CsrType              reqReg,       reqNext;
    logic                rdStrobe,     rdNext;
    logic                wrStrobe,     wrNext;
    CsrFbType            resp,         respNext;
    logic                respValid,    respValidNext;
    logic [TimerW-1:0]   timer,        timerNext;
    logic                timeoutPulse, timeoutNext;

    logic [IdxW-1:0]     pick;
    logic                pickValid;
    logic                accept;
    CsrType              inWord;

    // Round-robin pick: first valid port starting after the last grant.
    always_comb begin
        logic [IdxW-1:0] candIdx;
        int unsigned     cand;
        pick      = '0;
        pickValid = 1'b0;
        candIdx   = '0;
        cand      = 0;
        for (int unsigned off = 1; off <= Ports; off++) begin
            cand    = (32'(lastGrant) + off) % Ports;
            candIdx = IdxW'(cand);
            if (!pickValid && bus.wordInValid[candIdx]) begin
                pickValid = 1'b1;
                pick      = candIdx;
            end
        end
    end

    // Reset gating keeps ready low while reset is held.
    assign accept = (state == StIdle) && pickValid && reset;
    assign inWord = bus.wordInData[pick];

    always_comb begin
        for (int i = 0; i < int'(Ports); i++) begin
            bus.wordInReady[i] = accept && (pick == IdxW'(i));
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        stateNext     = state;
        lastGrantNext = lastGrant;
        ownerNext     = owner;
        reqNext       = reqReg;
        rdNext        = rdStrobe;
        wrNext        = wrStrobe;
        respNext      = resp;
        respValidNext = respValid;
        timerNext     = timer;
        timeoutNext   = 1'b0;

        case (state)
            StIdle: begin
                if (accept) begin
                    reqNext   = inWord;
                    ownerNext = pick;
                    if (inWord.read || inWord.write) begin
                        rdNext    = inWord.read;
                        wrNext    = inWord.write;
                        timerNext = '0;
                        stateNext = StWait;
                    end else begin
                        // Null request completes locally without a CSR cycle.
                        respNext       = '0;
                        respNext.ready = 1'b1;
                        respValidNext  = 1'b1;
                        stateNext      = StResp;
                    end
                end
            end
            StWait: begin
                // Target ready takes priority over a coincident timeout.
                if (bus.csrFb.ready) begin
                    respNext      = bus.csrFb;
                    rdNext        = 1'b0;
                    wrNext        = 1'b0;
                    respValidNext = 1'b1;
                    stateNext     = StResp;
                end else if ((TimeoutCycles != 0) &&
                             (timer == TimerW'(TimeoutCycles - 1))) begin
                    respNext       = '0;
                    respNext.error = 1'b1;
                    respNext.ready = 1'b1;
                    rdNext         = 1'b0;
                    wrNext         = 1'b0;
                    respValidNext  = 1'b1;
                    timeoutNext    = 1'b1;
                    stateNext      = StResp;
                end else begin
                    timerNext = timer + TimerW'(1);
                end
            end
            StResp: begin
                if (bus.wordOutReady[owner]) begin
                    respValidNext = 1'b0;
                    lastGrantNext = owner;
                    stateNext     = StIdle;
                end
            end
            default: begin
                stateNext = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            lastGrant    <= IdxW'(Ports - 1);
            owner        <= '0;
            reqReg       <= '0;
            rdStrobe     <= 1'b0;
            wrStrobe     <= 1'b0;
            resp         <= '0;
            respValid    <= 1'b0;
            timer        <= '0;
            timeoutPulse <= 1'b0;
        end else begin
            state        <= stateNext;
            lastGrant    <= lastGrantNext;
            owner        <= ownerNext;
            reqReg       <= reqNext;
            rdStrobe     <= rdNext;
            wrStrobe     <= wrNext;
            resp         <= respNext;
            respValid    <= respValidNext;
            timer        <= timerNext;
            timeoutPulse <= timeoutNext;
        end
    end

    // CSR bus: latched request with strobes from the strobe registers.
    always_comb begin
        bus.csr       = reqReg;
        bus.csr.read  = rdStrobe;
        bus.csr.write = wrStrobe;
    end

    // Response fan-out: shared data, valid only on the owning port.
    always_comb begin
        for (int i = 0; i < int'(Ports); i++) begin
            bus.wordOutData[i]  = resp;
            bus.wordOutValid[i] = respValid && (owner == IdxW'(i));
        end
    end

    assign bus.timeoutEvent = timeoutPulse;

endmodule

// File: tb/tb_oclib_words_to_csr_arb.sv
module tb_oclib_words_to_csr_arb;

    localparam int unsigned Ports = 2;
    localparam int unsigned Tmo   = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    oclib_words_to_csr_arb_if #(.Ports(Ports)) bus();

    oclib_words_to_csr_arb #(
        .Ports         (Ports),
        .TimeoutCycles (Tmo)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic oclib_pkg::csr_32_s mkReq(input logic [31:0] a, input logic [31:0] d,
                                                 input logic r, input logic w);
        oclib_pkg::csr_32_s q;
        q.address = a;
        q.wdata   = d;
        q.read    = r;
        q.write   = w;
        return q;
    endfunction

    function automatic oclib_pkg::csr_32_fb_s mkFb(input logic [31:0] d, input logic rdy,
                                                   input logic err);
        oclib_pkg::csr_32_fb_s f;
        f.rdata = d;
        f.ready = rdy;
        f.error = err;
        return f;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int grants[$];
        int overlap;
        int bad;
        oclib_pkg::csr_32_fb_s expResp;

        reset            = 1'b0;
        bus.wordInData   = '0;
        bus.wordInValid  = 2'b11;
        bus.wordOutReady = '0;
        bus.csrFb        = '0;
        #12;

        // Reset state
        check("rst_csr",    128'(bus.csr),          128'(0));
        check("rst_ovalid", 128'(bus.wordOutValid), 128'(0));
        check("rst_odata",  128'(bus.wordOutData),  128'(0));
        check("rst_tmo",    128'(bus.timeoutEvent), 128'(0));
        check("rst_iready", 128'(bus.wordInReady),  128'(0));
        bus.wordInValid = '0;
        @(negedge clock);
        reset = 1'b1;
        step();

        // Basic read on port 0, target ready 3 cycles after strobe rises
        bus.wordInData[0] = mkReq(32'h10, 32'h0, 1'b1, 1'b0);
        bus.wordInValid   = 2'b01;
        #1;
        check("rd_iready", 128'(bus.wordInReady), 128'(2'b01));
        check("rd_pre_lo", 128'(bus.csr.read),    128'(0));
        step();
        bus.wordInValid = '0;
        for (int k = 0; k < 3; k++) begin
            check("rd_strobe_hi", 128'(bus.csr.read),    128'(1));
            check("rd_addr",      128'(bus.csr.address), 128'(32'h10));
            if (k == 2) bus.csrFb = mkFb(32'hDEADBEEF, 1'b1, 1'b0);
            step();
        end
        bus.csrFb = '0;
        check("rd_strobe_lo", 128'(bus.csr.read),             128'(0));
        check("rd_ovalid",    128'(bus.wordOutValid),         128'(2'b01));
        check("rd_rdata",     128'(bus.wordOutData[0].rdata), 128'(32'hDEADBEEF));
        check("rd_err",       128'(bus.wordOutData[0].error), 128'(0));
        bus.wordOutReady = 2'b01;
        step();
        bus.wordOutReady = '0;
        check("rd_done", 128'(bus.wordOutValid), 128'(0));

        // Round-robin with both ports continuously valid; last grant was 0
        bus.wordInData[0] = mkReq(32'h100, 32'h0, 1'b1, 1'b0);
        bus.wordInData[1] = mkReq(32'h200, 32'h0, 1'b1, 1'b0);
        bus.wordInValid   = 2'b11;
        bus.wordOutReady  = 2'b11;
        overlap = 0;
        for (int c = 0; c < 200 && grants.size() < 6; c++) begin
            bus.csrFb = mkFb(32'h0, bus.csr.read | bus.csr.write, 1'b0);
            #1;
            if ($countones(bus.wordInReady) > 1) overlap++;
            if (bus.wordInReady == 2'b01) grants.push_back(0);
            else if (bus.wordInReady == 2'b10) grants.push_back(1);
            step();
        end
        bus.wordInValid = '0;
        for (int c = 0; c < 6; c++) begin
            bus.csrFb = mkFb(32'h0, bus.csr.read | bus.csr.write, 1'b0);
            #1;
            if ($countones(bus.wordInReady) > 1) overlap++;
            step();
        end
        bus.csrFb        = '0;
        bus.wordOutReady = '0;
        check("rr_count",   128'(grants.size()), 128'(6));
        check("rr_overlap", 128'(overlap),       128'(0));
        for (int i = 0; i < grants.size(); i++) begin
            check("rr_grant", 128'(grants[i]), 128'((i % 2 == 0) ? 1 : 0));
        end
        check("rr_idle", 128'(bus.wordOutValid), 128'(0));

        // Timeout: write with a silent target
        bus.wordInData[0] = mkReq(32'h30, 32'h55, 1'b0, 1'b1);
        bus.wordInValid   = 2'b01;
        #1;
        check("to_iready", 128'(bus.wordInReady), 128'(2'b01));
        step();
        bus.wordInValid = '0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.timeoutEvent !== 1'b0 || bus.wordOutValid !== 2'b00 || bus.csr.write !== 1'b1) bad++;
            step();
        end
        check("to_wait",   128'(bad),                           128'(0));
        check("to_pulse",  128'(bus.timeoutEvent),              128'(1));
        check("to_ovalid", 128'(bus.wordOutValid),              128'(2'b01));
        check("to_resp",   128'(bus.wordOutData[0]),            128'(mkFb(32'h0, 1'b1, 1'b1)));
        check("to_wr_lo",  128'(bus.csr.write),                 128'(0));
        bus.wordOutReady = 2'b01;
        step();
        bus.wordOutReady = '0;
        check("to_pulse_end", 128'(bus.timeoutEvent), 128'(0));
        check("to_done",      128'(bus.wordOutValid), 128'(0));
        repeat (4) step();
        bus.csrFb = mkFb(32'h1234, 1'b1, 1'b0);
        step();
        bus.csrFb = '0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.wordOutValid !== 2'b00 || bus.timeoutEvent !== 1'b0) bad++;
            step();
        end
        check("to_late_ignored", 128'(bad),                128'(0));
        check("to_late_data",    128'(bus.wordOutData[0]), 128'(mkFb(32'h0, 1'b1, 1'b1)));

        // Race: target ready on the exact timeout edge
        bus.wordInData[0] = mkReq(32'h40, 32'h77, 1'b0, 1'b1);
        bus.wordInValid   = 2'b01;
        step();
        bus.wordInValid = '0;
        repeat (7) step();
        bus.csrFb = mkFb(32'hA5A5A5A5, 1'b1, 1'b0);
        step();
        bus.csrFb = '0;
        check("race_tmo",    128'(bus.timeoutEvent),   128'(0));
        check("race_ovalid", 128'(bus.wordOutValid),   128'(2'b01));
        check("race_resp",   128'(bus.wordOutData[0]), 128'(mkFb(32'hA5A5A5A5, 1'b1, 1'b0)));
        bus.wordOutReady = 2'b01;
        step();
        bus.wordOutReady = '0;

        // Null request on port 1 with backpressure; port 0 waiting
        bus.wordInData[1] = mkReq(32'h50, 32'h0, 1'b0, 1'b0);
        bus.wordInValid   = 2'b10;
        #1;
        check("null_iready", 128'(bus.wordInReady), 128'(2'b10));
        step();
        bus.wordInData[0] = mkReq(32'h60, 32'h0, 1'b1, 1'b0);
        bus.wordInValid   = 2'b01;
        bus.wordOutReady  = 2'b01;
        #1;
        expResp = mkFb(32'h0, 1'b1, 1'b0);
        check("null_ovalid",  128'(bus.wordOutValid),    128'(2'b10));
        check("null_resp",    128'(bus.wordOutData[1]),  128'(expResp));
        check("null_nostrb",  128'({bus.csr.read, bus.csr.write}), 128'(0));
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.wordOutValid !== 2'b10 || bus.wordOutData[1] !== expResp ||
                bus.wordInReady !== 2'b00 || bus.csr.read !== 1'b0 || bus.csr.write !== 1'b0) bad++;
        end
        check("bp_stable", 128'(bad), 128'(0));
        bus.wordOutReady = 2'b10;
        step();
        bus.wordOutReady = '0;
        #1;
        check("bp_next_grant", 128'(bus.wordInReady), 128'(2'b01));

        // Async reset during StWait
        step();
        bus.wordInData[1] = mkReq(32'h70, 32'h0, 1'b1, 1'b0);
        bus.wordInValid   = 2'b11;
        check("ar_wait_rd", 128'(bus.csr.read), 128'(1));
        #2;
        reset = 1'b0;
        #1;
        check("ar_csr",    128'(bus.csr),          128'(0));
        check("ar_ovalid", 128'(bus.wordOutValid), 128'(0));
        check("ar_iready", 128'(bus.wordInReady),  128'(0));
        #2;
        reset = 1'b1;
        #1;
        check("ar_first_grant", 128'(bus.wordInReady), 128'(2'b01));
        step();
        bus.wordInValid = '0;
        check("ar_accept_rd",   128'(bus.csr.read),    128'(1));
        check("ar_accept_addr", 128'(bus.csr.address), 128'(32'h60));
        bus.csrFb = mkFb(32'h0, 1'b1, 1'b0);
        step();
        bus.csrFb        = '0;
        bus.wordOutReady = 2'b01;
        step();
        bus.wordOutReady = '0;
        check("ar_done", 128'(bus.wordOutValid), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
